// File: rtl/strip_pool_pkg.sv
// Shared types and helpers for the strip ReLU + 2x2 max-pool stage.
// State encoding, pooled-dimension helper, default read latency.
package strip_pool_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_EMIT,
    S_NEXT,
    S_DONE
  } state_t;

  localparam int RD_LAT_DEF = 2;

  function automatic int pool_dim(input int n);
    return n / 2;
  endfunction

endpackage

// File: rtl/pool_window_max.sv
// Running ReLU-folded max of one 2x2 pooling window.
// Ports: clk, reset, clear, cap, sample (signed) -> max_o (signed).
module pool_window_max
  import strip_pool_pkg::*;
#(
  parameter int DATA_W = 9
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     cap,
  input  logic signed [DATA_W-1:0] sample,
  output logic signed [DATA_W-1:0] max_o
);

  logic signed [DATA_W-1:0] max_q;
  logic signed [DATA_W-1:0] max_d;

  // Starting from 0 folds ReLU into the max.
  always_comb begin
    max_d = max_q;
    if (clear) begin
      max_d = '0;
    end else if (cap && (sample > max_q)) begin
      max_d = sample;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      max_q <= '0;
    end else begin
      max_q <= max_d;
    end
  end

  assign max_o = max_q;

endmodule

// File: rtl/strip_relu_maxpool.sv
// Reads one strip of conv results, applies ReLU + 2x2/2 max pool.
// Ports: start/conv_done in, rd_addr/rd_data memory port, out_* stream, busy/done.
module strip_relu_maxpool
  import strip_pool_pkg::*;
#(
  parameter int IN_W   = 222,
  parameter int IN_H   = 28,
  parameter int DATA_W = 9,
  parameter int ADDR_W = 16,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     conv_done,
  output logic [ADDR_W-1:0]        rd_addr,
  input  logic signed [DATA_W-1:0] rd_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_data,
  output logic [ADDR_W-1:0]        out_index,
  output logic                     busy,
  output logic                     done
);

  localparam int OUT_W = pool_dim(IN_W);
  localparam int OUT_H = pool_dim(IN_H);
  localparam int DC_W  = $clog2(RD_LAT + 1);
  localparam logic [ADDR_W-1:0] PCOL_LAST = ADDR_W'(OUT_W - 1);
  localparam logic [ADDR_W-1:0] PROW_LAST = ADDR_W'(OUT_H - 1);

  state_t              state_q, state_d;
  logic [1:0]          fcnt_q, fcnt_d;
  logic [DC_W-1:0]     dcnt_q, dcnt_d;
  logic [ADDR_W-1:0]   pcol_q, pcol_d;
  logic [ADDR_W-1:0]   prow_q, prow_d;
  logic [ADDR_W-1:0]   oidx_q, oidx_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [RD_LAT-1:0]   tag_q, tag_d;
  logic                clear;
  logic                go;
  logic signed [DATA_W-1:0] max_v;

  // Address k of the window at (pr, pc): k[1] selects row, k[0] column.
  function automatic logic [ADDR_W-1:0] win_addr(
    input logic [ADDR_W-1:0] pr,
    input logic [ADDR_W-1:0] pc,
    input logic [1:0]        k
  );
    logic [ADDR_W-1:0] a;
    a = ADDR_W'(2 * IN_W) * pr + (pc << 1);
    if (k[1]) a = a + ADDR_W'(IN_W);
    if (k[0]) a = a + ADDR_W'(1);
    return a;
  endfunction

  assign go = start & conv_done;

  always_comb begin
    state_d   = state_q;
    fcnt_d    = fcnt_q;
    dcnt_d    = dcnt_q;
    pcol_d    = pcol_q;
    prow_d    = prow_q;
    oidx_d    = oidx_q;
    rd_addr_d = rd_addr_q;
    clear     = 1'b0;
    // Tag bit i set: a read issued i+1 cycles ago lands rd_data now.
    tag_d     = RD_LAT'({tag_q, state_q == S_FETCH});
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (go) begin
          state_d = S_FETCH;
          pcol_d  = '0;
          prow_d  = '0;
          oidx_d  = '0;
        end
      end
      S_FETCH: begin
        if (fcnt_q == 2'd3) begin
          state_d = S_DRAIN;
          dcnt_d  = '0;
        end else begin
          fcnt_d    = fcnt_q + 2'd1;
          rd_addr_d = win_addr(prow_q, pcol_q, fcnt_q + 2'd1);
        end
      end
      S_DRAIN: begin
        if (dcnt_q == DC_W'(RD_LAT - 1)) begin
          state_d = S_EMIT;
        end else begin
          dcnt_d = dcnt_q + DC_W'(1);
        end
      end
      S_EMIT: begin
        if (out_ready) state_d = S_NEXT;
      end
      S_NEXT: begin
        oidx_d = oidx_q + ADDR_W'(1);
        if (pcol_q < PCOL_LAST) begin
          pcol_d  = pcol_q + ADDR_W'(1);
          state_d = S_FETCH;
        end else if (prow_q < PROW_LAST) begin
          pcol_d  = '0;
          prow_d  = prow_q + ADDR_W'(1);
          state_d = S_FETCH;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Every FETCH entry restarts the window: first address and max.
    if (state_d == S_FETCH && state_q != S_FETCH) begin
      fcnt_d    = 2'd0;
      clear     = 1'b1;
      rd_addr_d = win_addr(prow_d, pcol_d, 2'd0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      fcnt_q    <= '0;
      dcnt_q    <= '0;
      pcol_q    <= '0;
      prow_q    <= '0;
      oidx_q    <= '0;
      rd_addr_q <= '0;
      tag_q     <= '0;
    end else begin
      state_q   <= state_d;
      fcnt_q    <= fcnt_d;
      dcnt_q    <= dcnt_d;
      pcol_q    <= pcol_d;
      prow_q    <= prow_d;
      oidx_q    <= oidx_d;
      rd_addr_q <= rd_addr_d;
      tag_q     <= tag_d;
    end
  end

  pool_window_max #(
    .DATA_W(DATA_W)
  ) u_max (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .cap   (tag_q[RD_LAT-1]),
    .sample(rd_data),
    .max_o (max_v)
  );

  // max_v is never negative; upper bits only matter for wider DATA_W.
  assign out_data  = (|max_v[DATA_W-1:8]) ? 8'hFF : max_v[7:0];
  assign rd_addr   = rd_addr_q;
  assign out_valid = (state_q == S_EMIT);
  assign out_index = oidx_q;
  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_strip_relu_maxpool.sv
// Scoreboard bench: 4x4, 5x5 and default-size instances of the pool stage.
// Directed windows with hand-computed maxima; monitor pops on handshake.
module tb_strip_relu_maxpool;

  typedef struct {
    logic [7:0]  d;
    logic [15:0] idx;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst  [3];
  logic              st   [3];
  logic              cd   [3];
  logic [15:0]       ra   [3];
  logic signed [8:0] rdd  [3];
  logic signed [8:0] p1   [3];
  logic              ov   [3];
  logic              rdy  [3];
  logic [7:0]        od   [3];
  logic [15:0]       oi   [3];
  logic              bz   [3];
  logic              dn   [3];

  exp_t exp_q [3][$];
  exp_t e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   hs_cnt   [3];
  int   last_idx [3];
  int   bad_addr = 0;
  logic mode_neg = 1'b0;

  always #5 clk = ~clk;

  strip_relu_maxpool #(.IN_W(4), .IN_H(4)) u_a (
    .clk(clk), .reset(rst[0]), .start(st[0]), .conv_done(cd[0]),
    .rd_addr(ra[0]), .rd_data(rdd[0]), .out_valid(ov[0]),
    .out_ready(rdy[0]), .out_data(od[0]), .out_index(oi[0]),
    .busy(bz[0]), .done(dn[0]));

  strip_relu_maxpool #(.IN_W(5), .IN_H(5)) u_b (
    .clk(clk), .reset(rst[1]), .start(st[1]), .conv_done(cd[1]),
    .rd_addr(ra[1]), .rd_data(rdd[1]), .out_valid(ov[1]),
    .out_ready(rdy[1]), .out_data(od[1]), .out_index(oi[1]),
    .busy(bz[1]), .done(dn[1]));

  strip_relu_maxpool u_c (
    .clk(clk), .reset(rst[2]), .start(st[2]), .conv_done(cd[2]),
    .rd_addr(ra[2]), .rd_data(rdd[2]), .out_valid(ov[2]),
    .out_ready(rdy[2]), .out_data(od[2]), .out_index(oi[2]),
    .busy(bz[2]), .done(dn[2]));

  function automatic logic signed [8:0] mem_val(input int i, input logic [15:0] a);
    if (i < 2) return 9'(int'(a) - 8);
    if (mode_neg) return 9'(-(int'(a % 16'd256) + 1));
    return 9'(a % 16'd256);
  endfunction

  // Conv result memory with a 2-cycle read pipeline.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      p1[i]  <= mem_val(i, ra[i]);
      rdd[i] <= p1[i];
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst[i] && ov[i] && rdy[i]) begin
        n_cmp++;
        if (exp_q[i].size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_out inst%0d: got data %0d index %0d, required none",
                   i, od[i], oi[i]);
        end else begin
          e = exp_q[i].pop_front();
          if (od[i] !== e.d || oi[i] !== e.idx) begin
            n_bad++;
            $display("FAIL out inst%0d: got data %0d index %0d, required data %0d index %0d",
                     i, od[i], oi[i], e.d, e.idx);
          end
        end
        hs_cnt[i]++;
        last_idx[i] = int'(oi[i]);
      end
    end
    if (bz[1] && ((ra[1] % 16'd5) == 16'd4 || ra[1] >= 16'd20)) bad_addr++;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", nm, got, req);
    end
  endtask

  task automatic push(input int i, input logic [7:0] d, input logic [15:0] idx);
    exp_t x;
    x.d   = d;
    x.idx = idx;
    exp_q[i].push_back(x);
  endtask

  task automatic wait_hs(input int i, input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (!(ov[i] && rdy[i]) && n < 400) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (n >= 400) begin
      n_bad++;
      $display("FAIL %s: got no handshake in 400 cycles, required one", nm);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int i);
    @(posedge clk);
    #1 st[i] = 1'b1;
    @(posedge clk);
    #1 st[i] = 1'b0;
  endtask

  task automatic chk_reset(input int i, input string nm);
    chk({nm, "_rd_addr"},   32'(ra[i]), 0);
    chk({nm, "_out_valid"}, 32'(ov[i]), 0);
    chk({nm, "_out_data"},  32'(od[i]), 0);
    chk({nm, "_out_index"}, 32'(oi[i]), 0);
    chk({nm, "_busy"},      32'(bz[i]), 0);
    chk({nm, "_done"},      32'(dn[i]), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish by 400us, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  hd;
    logic [15:0] hi, ha;
    int          n;
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; st[i] = 1'b0; cd[i] = 1'b0; rdy[i] = 1'b1;
      hs_cnt[i] = 0; last_idx[i] = -1;
    end
    repeat (3) @(posedge clk);
    #1;
    chk_reset(0, "rst_a");
    chk_reset(2, "rst_c");
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;

    push(0, 8'd0, 16'd0); push(0, 8'd0, 16'd1);
    push(0, 8'd5, 16'd2); push(0, 8'd7, 16'd3);
    push(1, 8'd0, 16'd0); push(1, 8'd0, 16'd1);
    push(1, 8'd8, 16'd2); push(1, 8'd10, 16'd3);
    cd[0] = 1'b1; cd[1] = 1'b1;
    @(posedge clk);
    #1 st[0] = 1'b1; st[1] = 1'b1;
    @(posedge clk);
    #1 st[0] = 1'b0; st[1] = 1'b0;

    // start without conv_done is ignored
    cd[2] = 1'b0;
    pulse_start(2);
    repeat (3) begin
      @(negedge clk);
      chk("nocd_busy", 32'(bz[2]), 0);
      chk("nocd_rd_addr", 32'(ra[2]), 0);
    end

    // positive ramp: window k in row 0 peaks at 223+2k
    mode_neg = 1'b0;
    push(2, 8'd223, 16'd0); push(2, 8'd225, 16'd1); push(2, 8'd227, 16'd2);
    cd[2] = 1'b1;
    pulse_start(2);
    wait_hs(2, "hs_w0");
    rdy[2] = 1'b0;
    n = 0;
    @(negedge clk);
    while (!ov[2] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_timeout", 32'(n < 50), 1);
    hd = od[2]; hi = oi[2]; ha = ra[2];
    repeat (10) begin
      @(negedge clk);
      chk("bp_valid", 32'(ov[2]), 1);
      chk("bp_data", 32'(od[2]), 32'(hd));
      chk("bp_index", 32'(oi[2]), 32'(hi));
      chk("bp_rd_addr", 32'(ra[2]), 32'(ha));
    end
    @(posedge clk);
    #1 rdy[2] = 1'b1;
    wait_hs(2, "hs_w1");

    // start while busy is ignored
    pulse_start(2);
    chk("midstart_busy", 32'(bz[2]), 1);
    wait_hs(2, "hs_w2");
    repeat (5) @(posedge clk);
    #1;
    chk("drain_w3_rd_addr", 32'(ra[2]), 229);
    rst[2] = 1'b1;
    #1;
    chk_reset(2, "drain_rst");
    chk("drain_rst_queue", 32'(exp_q[2].size()), 0);
    repeat (2) @(posedge clk);
    #1 rst[2] = 1'b0;

    // fresh start: window 0 first, valid 6 cycles after first FETCH
    push(2, 8'd223, 16'd0);
    pulse_start(2);
    n = 0;
    while (!ov[2] && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("first_valid_latency", 32'(n), 6);
    wait_hs(2, "hs_fresh");
    rst[2] = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst[2] = 1'b0;

    // full default strip of negative values: all zeros
    mode_neg = 1'b1;
    hs_cnt[2] = 0;
    for (int k = 0; k < 1554; k++) push(2, 8'd0, 16'(k));
    pulse_start(2);
    n = 0;
    while (!dn[2] && n < 20000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("full_done", 32'(dn[2]), 1);
    chk("full_busy", 32'(bz[2]), 0);
    chk("full_count", 32'(hs_cnt[2]), 1554);
    chk("full_last_index", 32'(last_idx[2]), 1553);

    chk("a_done", 32'(dn[0]), 1);
    chk("a_count", 32'(hs_cnt[0]), 4);
    chk("b_done", 32'(dn[1]), 1);
    chk("b_count", 32'(hs_cnt[1]), 4);
    chk("b_edge_addr", 32'(bad_addr), 0);
    for (int i = 0; i < 3; i++) chk("queue_empty", 32'(exp_q[i].size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/strip_relu_maxpool.md
# strip_relu_maxpool

Post-convolution stage for one horizontal strip. Once the strip convolution unit reports done, this block reads the strip's convolution results back through that unit's random-access read port. It applies ReLU and 2x2 stride-2 max pooling, and streams the pooled 8-bit activations downstream over a valid/ready interface. One instance sits directly after each strip convolution unit.

## Interface
- IN_W, 222: conv output columns per strip.
- IN_H, 28: conv output rows per strip.
- DATA_W, 9: signed conv result width.
- ADDR_W, 16: read address width.
- RD_LAT, 2: cycles from rd_addr change to valid rd_data.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  begin a strip; honoured only in IDLE or DONE with conv_done=1.
- conv_done  in  1  upstream conv unit has finished writing its strip.
- rd_addr  out  ADDR_W  read address into conv result memory (row-major, row*IN_W+col).
- rd_data  in  DATA_W  signed conv result, valid RD_LAT cycles after rd_addr.
- out_valid  out  1  pooled sample available.
- out_ready  in  1  downstream accepts when out_valid&out_ready.
- out_data  out  8  pooled activation, unsigned.
- out_index  out  ADDR_W  pooled position, prow*OUT_W+pcol.
- busy  out  1  high from accepted start until DONE.
- done  out  1  level-high in DONE; cleared by next accepted start.

## Operation
- OUT_W = IN_W/2 and OUT_H = IN_H/2 use floor division. Defaults give 111x14 = 1554 outputs.
- An odd trailing column or row is never read.
- States:
  - IDLE: start&conv_done -> FETCH. Clear pcol, prow, out_index; busy=1.
  - FETCH: 4 cycles. Drive base, base+1, base+IN_W, base+IN_W+1 in order, where base = 2*prow*IN_W + 2*pcol. Then -> DRAIN.
  - DRAIN: RD_LAT cycles. Finish capturing the issued reads. Then -> EMIT.
  - EMIT: out_valid=1, data and index stable. On out_ready -> NEXT.
  - NEXT: one cycle.
    - If pcol<OUT_W-1: pcol++.
    - Else if prow<OUT_H-1: pcol=0, prow++.
    - Else -> DONE.
    - out_index++ in every case; otherwise -> FETCH.
  - DONE: done=1, busy=0. start&conv_done -> FETCH with counters cleared.
- Arithmetic:
  - Running max is a 9-bit signed register, initialised to 0 at FETCH entry; ReLU is folded into this max.
  - Each captured sample s gives m = (s>m) ? s : m, with a signed compare.
  - out_data = m[7:0]. The 9-bit signed maximum of 255 fits, so no saturation is needed.
- Read capture: a RD_LAT-deep tag shift register marks which cycles carry valid rd_data. Capture happens only when the tag is set.
- start while busy is ignored. start with conv_done=0 is ignored.

## Timing
- Reset values:
  - rd_addr=0, out_valid=0, out_data=0, out_index=0, busy=0, done=0.
  - State IDLE; all counters and the max register at 0.
- rd_addr is registered. Address k of a window appears in FETCH cycle k (k=0..3).
- out_valid rises RD_LAT+4 cycles after the first FETCH cycle, which is 6 for defaults.
- Window cost without stall is 4 + RD_LAT + 1 (EMIT) + 1 (NEXT) = 8 cycles. Each cycle out_ready=0 in EMIT adds one cycle.
- out_data and out_index hold stable while out_valid=1 and out_ready=0.
- done rises in the cycle after the NEXT that retires the final output.
- Asynchronous reset at any point returns to IDLE immediately. Pending reads are discarded, and no partial window is emitted after reset release.

## Structure
- Shared package strip_pool_pkg holds:
  - state encoding (IDLE, FETCH, DRAIN, EMIT, NEXT, DONE);
  - OUT_W/OUT_H derivation function;
  - default RD_LAT.
- One sub-module, pool_window_max: clear, capture-enable, 9-bit signed sample in; 9-bit running max out. It holds the ReLU-folded max and nothing else.
- Address generation, the FSM and the tag shift register live in the top level.

## Test plan
- IN_W=4, IN_H=4, memory model value = addr-8 (-8..7):
  - Expect 4 outputs.
  - out_data = 0, 0, 5, 7; out_index = 0..3.
  - done high after the fourth handshake.
- All rd_data negative (-256..-1), defaults: expect 1554 outputs, all out_data=0, final out_index=1553.
- IN_W=5, IN_H=5: expect 4 outputs, and column 4 and row 4 addresses never appear on rd_addr.
- Backpressure: hold out_ready=0 for 10 cycles on the 2nd output. out_data and out_index must stay constant, and the next rd_addr must not change before the handshake.
- Assert reset during DRAIN of window 3. All outputs must read their reset values next cycle. A fresh start must produce window 0 first with the correct value.
- Pulse start with conv_done=0: state stays IDLE and busy stays 0. Pulse start mid-strip: no restart, and the output count is unchanged.
